// File: rtl/event_wrr_sched.sv
// Weighted round-robin scheduler that merges PORTS event streams into one
// registered output stream. Each grant serves a burst of up to weight[p] events.
module event_wrr_sched #(
   parameter int unsigned PORTS              = 4,
   parameter int unsigned QUEUE_INDEX_WIDTH  = 4,
   parameter int unsigned EVENT_TYPE_WIDTH   = 16,
   parameter int unsigned EVENT_SOURCE_WIDTH = 16,
   parameter int unsigned WEIGHT_WIDTH       = 8,
   parameter int unsigned DEFAULT_WEIGHT     = 1
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  enable,
   input  logic [$clog2(PORTS)-1:0]              cfg_port,
   input  logic [WEIGHT_WIDTH-1:0]               cfg_weight,
   input  logic                                  cfg_we,
   input  logic [PORTS*QUEUE_INDEX_WIDTH-1:0]    s_axis_event_queue,
   input  logic [PORTS*EVENT_TYPE_WIDTH-1:0]     s_axis_event_type,
   input  logic [PORTS*EVENT_SOURCE_WIDTH-1:0]   s_axis_event_source,
   input  logic [PORTS-1:0]                      s_axis_event_valid,
   output logic [PORTS-1:0]                      s_axis_event_ready,
   output logic [QUEUE_INDEX_WIDTH-1:0]          m_axis_event_queue,
   output logic [EVENT_TYPE_WIDTH-1:0]           m_axis_event_type,
   output logic [EVENT_SOURCE_WIDTH-1:0]         m_axis_event_source,
   output logic [$clog2(PORTS)-1:0]              m_axis_event_port,
   output logic                                  m_axis_event_valid,
   input  logic                                  m_axis_event_ready,
   output logic                                  busy
);

   localparam int unsigned PW = $clog2(PORTS);
   localparam int unsigned QW = QUEUE_INDEX_WIDTH;
   localparam int unsigned TW = EVENT_TYPE_WIDTH;
   localparam int unsigned SW = EVENT_SOURCE_WIDTH;
   localparam int unsigned WW = WEIGHT_WIDTH;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SERVE = 1'b1
   } state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   rr_ptr, rr_ptr_nxt;
   logic [PW-1:0]   cur, cur_nxt;
   logic [WW-1:0]   cnt, cnt_nxt;
   logic [WW-1:0]   wgt_lat, wgt_lat_nxt;
   logic [WW-1:0]   weight [PORTS];

   logic            can_accept;
   logic            xfer;
   logic [PW-1:0]   cur_inc;
   logic [WW-1:0]   cnt_inc;
   logic            sel_found;
   logic [PW-1:0]   sel_port;

   // Output register can take a new event when empty or draining this cycle.
   assign can_accept = !m_axis_event_valid || m_axis_event_ready;
   assign xfer       = (state == SERVE) && s_axis_event_valid[cur] && can_accept;
   assign cnt_inc    = cnt + WW'(1);
   assign busy       = (state == SERVE);

   // Successor of the current port, wrapping for non-power-of-two PORTS.
   always_comb begin
      cur_inc = cur + PW'(1);
      if (32'(cur) == PORTS - 1) begin
         cur_inc = '0;
      end
   end

   // First valid port with non-zero weight, searching from rr_ptr upwards.
   always_comb begin
      int unsigned   idx;
      logic [PW-1:0] idx_p;
      sel_found = 1'b0;
      sel_port  = '0;
      idx       = 0;
      idx_p     = '0;
      for (int unsigned i = 0; i < PORTS; i++) begin
         idx = 32'(rr_ptr) + i;
         if (idx >= PORTS) begin
            idx = idx - PORTS;
         end
         idx_p = PW'(idx);
         if (!sel_found && s_axis_event_valid[idx_p] && (weight[idx_p] != '0)) begin
            sel_found = 1'b1;
            sel_port  = idx_p;
         end
      end
   end

   // Next-state logic: grant selection in IDLE, burst accounting in SERVE.
   always_comb begin
      state_nxt          = state;
      rr_ptr_nxt         = rr_ptr;
      cur_nxt            = cur;
      cnt_nxt            = cnt;
      wgt_lat_nxt        = wgt_lat;
      s_axis_event_ready = '0;
      case (state)
         IDLE: begin
            if (enable && sel_found) begin
               state_nxt   = SERVE;
               cur_nxt     = sel_port;
               cnt_nxt     = '0;
               wgt_lat_nxt = weight[sel_port];
            end
         end
         SERVE: begin
            s_axis_event_ready[cur] = can_accept;
            if (!s_axis_event_valid[cur]) begin
               // Source ran dry: the rest of its turn is forfeited.
               state_nxt  = IDLE;
               rr_ptr_nxt = cur_inc;
            end else if (can_accept) begin
               cnt_nxt = cnt_inc;
               if (cnt_inc == wgt_lat) begin
                  state_nxt  = IDLE;
                  rr_ptr_nxt = cur_inc;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Scheduler state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         rr_ptr  <= '0;
         cur     <= '0;
         cnt     <= '0;
         wgt_lat <= '0;
      end else begin
         state   <= state_nxt;
         rr_ptr  <= rr_ptr_nxt;
         cur     <= cur_nxt;
         cnt     <= cnt_nxt;
         wgt_lat <= wgt_lat_nxt;
      end
   end

   // Per-port weight table; out-of-range port writes are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < PORTS; i++) begin
            weight[i] <= WW'(DEFAULT_WEIGHT);
         end
      end else if (cfg_we && (32'(cfg_port) < PORTS)) begin
         weight[cfg_port] <= cfg_weight;
      end
   end

   // Output valid: set on transfer, cleared once the consumer takes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_axis_event_valid <= 1'b0;
      end else if (xfer) begin
         m_axis_event_valid <= 1'b1;
      end else if (m_axis_event_ready) begin
         m_axis_event_valid <= 1'b0;
      end
   end

   // Output payload: loaded only on transfer, so it holds while stalled.
   always_ff @(posedge clk) begin
      if (xfer) begin
         m_axis_event_queue  <= s_axis_event_queue[cur*QW +: QW];
         m_axis_event_type   <= s_axis_event_type[cur*TW +: TW];
         m_axis_event_source <= s_axis_event_source[cur*SW +: SW];
         m_axis_event_port   <= cur;
      end
   end

endmodule

// File: doc/event_wrr_sched.md
Name: event_wrr_sched

Overview:
Weighted round-robin scheduler that shares one event output stream between PORTS event sources (queue/type/source triplets) with per-port burst weights.
- Sits in front of event consumers (interrupt/EQ logic), where a plain mux gives unfair service under bursty completion traffic.
- Per-port weights are runtime-configurable; a registered output stage decouples timing.

Parameters:
PORTS, 4, number of event input ports (>=2)
QUEUE_INDEX_WIDTH, 4, event queue index width
EVENT_TYPE_WIDTH, 16, event type field width
EVENT_SOURCE_WIDTH, 16, event source field width
WEIGHT_WIDTH, 8, per-port weight width
DEFAULT_WEIGHT, 1, weight loaded into every port at reset

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
enable  in  1  allow new grants
cfg_port  in  $clog2(PORTS)  port whose weight is written
cfg_weight  in  WEIGHT_WIDTH  new weight; 0 = port disabled
cfg_we  in  1  weight write strobe
s_axis_event_queue  in  PORTS*QUEUE_INDEX_WIDTH  per-port queue index
s_axis_event_type  in  PORTS*EVENT_TYPE_WIDTH  per-port event type
s_axis_event_source  in  PORTS*EVENT_SOURCE_WIDTH  per-port event source
s_axis_event_valid  in  PORTS  per-port valid
s_axis_event_ready  out  PORTS  per-port ready
m_axis_event_queue  out  QUEUE_INDEX_WIDTH  output queue index
m_axis_event_type  out  EVENT_TYPE_WIDTH  output type
m_axis_event_source  out  EVENT_SOURCE_WIDTH  output source
m_axis_event_port  out  $clog2(PORTS)  index of port that supplied the event
m_axis_event_valid  out  1  output valid
m_axis_event_ready  in  1  output ready
busy  out  1  high while in SERVE state

Behaviour:
Reset:
- m_axis_event_valid=0, s_axis_event_ready=0, busy=0.
- State IDLE, rr_ptr=0, all weights=DEFAULT_WEIGHT.
- Output data registers need no reset.

Output stage:
- Single register. can_accept = !m_valid | m_ready.
- Transfer to output occurs when s_valid[cur] & s_ready[cur]; m_valid is high the following cycle (latency 1).
- m_valid clears when m_ready is high and no new transfer occurs that cycle.
- Full throughput within a burst: 1 event/cycle while m_ready is held high.

State machine:
- IDLE:
  - busy=0; all s_ready=0.
  - If enable=1: search ports rr_ptr, rr_ptr+1, ... (mod PORTS) for the first p with s_valid[p]=1 and weight[p]!=0.
  - If found: cur=p, cnt=0, wgt_lat=weight[p], go to SERVE.
  - If not found: stay IDLE.
  - Selection costs exactly one cycle per burst.
- SERVE:
  - busy=1; s_ready[cur]=can_accept; other s_ready=0.
  - On transfer: cnt++. If cnt+1==wgt_lat, go to IDLE with rr_ptr=(cur+1) mod PORTS.
  - If s_valid[cur]=0 in a cycle, go to IDLE with rr_ptr=(cur+1) mod PORTS; the port forfeits the remainder of its turn.
  - enable=0 during SERVE does not abort; the burst completes normally.
- Wrap: rr_ptr and the search index wrap from PORTS-1 to 0. Non-power-of-two PORTS must be handled; indices >=PORTS are never selected.

Configuration:
- cfg_we writes weight[cfg_port] on the next edge.
- cfg_port >= PORTS is ignored.
- A write to the port currently in SERVE affects only its next turn, because wgt_lat is latched at grant.
- A write in the same cycle as IDLE selection of that port: selection uses the old weight.

Counter:
- cnt is WEIGHT_WIDTH bits; maximum burst is 2^WEIGHT_WIDTH-1; no overflow is possible.

Handshake:
- s_ready is independent of that port's s_valid.
- Data is stable in the output register while m_valid=1 & m_ready=0.

Reset mid-operation:
- Any in-flight output event is discarded (m_valid=0 next cycle).
- Weights return to default.

Test Plan:
1. Fair share: PORTS=4, all weights 1, all ports continuously valid, m_ready=1 -> m_axis_event_port sequence 0,1,2,3,0... Each event separated by one IDLE cycle; 50% throughput.
2. Weighted: weights {3,1,0,2}, all valid -> port sequence 0,0,0,1,3,3 repeating. Port 2 is never granted; s_ready[2] is never asserted.
3. Backpressure: weight[0]=4, m_ready toggles 1,0,0,1,... -> no event lost or duplicated. Output data is held stable while stalled, and exactly 4 port-0 events are emitted before port 1 is served.
4. Early drop: weight[1]=5, port 1 supplies only 2 events, then deasserts valid -> SERVE exits after 2 events and rr_ptr=2; the next grant goes to port 2 if valid.
5. Config during burst: port 0 in SERVE with weight 4; write weight[0]=1 after its first transfer -> the current burst still emits 4 events, and the next port-0 turn emits 1.
6. Reset/enable: assert rst mid-burst with m_valid=1 -> m_valid=0, busy=0, rr_ptr=0 the next cycle. With enable=0 and all ports valid -> no grants and busy stays 0.
